usb_wb_arbiter: RTL and testbench

//  Two-master Wishbone arbiter and address decoder for the shared 8-bit register bus
//  of the usbHost/usbSlave pair. Grants one master per cycle, round-robin.

---
 rtl/usb_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_usb_wb_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : usb_wb_arbiter
// Brief    : Round-robin two-master Wishbone arbiter and host/slave decoder
//            for the shared usbHost/usbSlave register bus, with no-ack timeout.
// Revision : 1.0 - initial release
// ============================================================================
module usb_wb_arbiter #(
    parameter int AWIDTH   = 9,
    parameter int DWIDTH   = 8,
    parameter int TIMEOUT  = 16,
    parameter int TO_WIDTH = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [AWIDTH-1:0] m0_adr_i,
    input  logic [DWIDTH-1:0] m0_dat_i,
    output logic [DWIDTH-1:0] m0_dat_o,
    input  logic              m0_we_i,
    input  logic              m0_stb_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic [AWIDTH-1:0] m1_adr_i,
    input  logic [DWIDTH-1:0] m1_dat_i,
    output logic [DWIDTH-1:0] m1_dat_o,
    input  logic              m1_we_i,
    input  logic              m1_stb_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [AWIDTH-2:0] s_adr_o,
    output logic [DWIDTH-1:0] s_dat_o,
    output logic              s_we_o,
    output logic              host_stb_o,
    input  logic [DWIDTH-1:0] host_dat_i,
    input  logic              host_ack_i,
    output logic              slave_stb_o,
    input  logic [DWIDTH-1:0] slave_dat_i,
    input  logic              slave_ack_i,
    output logic [1:0]        grant_o,
    output logic              busy_o
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_BUSY    = 2'd1;
    localparam logic [1:0] c_RELEASE = 2'd2;
    localparam logic [TO_WIDTH-1:0] c_TO_LAST = TO_WIDTH'(TIMEOUT - 1);

    logic [1:0]          r_state;
    logic [1:0]          r_grant;
    logic                r_last;    // 1 = m1 was the last master served
    logic [TO_WIDTH-1:0] r_count;

    logic                w_gStb;
    logic [AWIDTH-1:0]   w_gAdr;
    logic [DWIDTH-1:0]   w_gDat;
    logic                w_gWe;
    logic                w_sel;
    logic                w_selAck;
    logic [DWIDTH-1:0]   w_selDat;
    logic                w_timeout;

    // Grant is only non-zero in BUSY, so it alone qualifies every slave-side path.
    assign w_gStb = (r_grant[0] & m0_stb_i) | (r_grant[1] & m1_stb_i);
    assign w_gAdr = r_grant[1] ? m1_adr_i : (r_grant[0] ? m0_adr_i : '0);
    assign w_gDat = r_grant[1] ? m1_dat_i : (r_grant[0] ? m0_dat_i : '0);
    assign w_gWe  = r_grant[1] ? m1_we_i  : (r_grant[0] & m0_we_i);
    assign w_sel  = w_gAdr[AWIDTH-1];

    assign w_selAck  = w_gStb & (w_sel ? slave_ack_i : host_ack_i);
    assign w_selDat  = w_sel ? slave_dat_i : host_dat_i;
    assign w_timeout = w_gStb & ~w_selAck & (r_count == c_TO_LAST);

    assign s_adr_o     = w_gAdr[AWIDTH-2:0];
    assign s_dat_o     = w_gDat;
    assign s_we_o      = w_gWe;
    assign host_stb_o  = w_gStb & ~w_sel;
    assign slave_stb_o = w_gStb & w_sel;

    assign m0_ack_o = r_grant[0] & w_selAck;
    assign m1_ack_o = r_grant[1] & w_selAck;
    assign m0_err_o = r_grant[0] & w_timeout;
    assign m1_err_o = r_grant[1] & w_timeout;
    assign m0_dat_o = r_grant[0] ? w_selDat : '0;
    assign m1_dat_o = r_grant[1] ? w_selDat : '0;

    assign grant_o = r_grant;
    assign busy_o  = (r_state == c_BUSY) | (r_state == c_RELEASE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
            r_grant <= 2'b00;
            r_last  <= 1'b1;
            r_count <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_count <= '0;
                    if (m0_stb_i | m1_stb_i) begin
                        r_state <= c_BUSY;
                        // On a tie the master not served last wins.
                        if (m0_stb_i && (!m1_stb_i || r_last)) r_grant <= 2'b01;
                        else                                   r_grant <= 2'b10;
                    end
                end
                c_BUSY: begin
                    if (!w_gStb) begin
                        r_state <= c_IDLE;
                        r_grant <= 2'b00;
                        r_count <= '0;
                    end else if (w_selAck || w_timeout) begin
                        r_state <= c_RELEASE;
                        r_grant <= 2'b00;
                        r_last  <= r_grant[1];
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + TO_WIDTH'(1);
                    end
                end
                c_RELEASE: begin
                    r_state <= c_IDLE;
                    r_count <= '0;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_grant <= 2'b00;
                    r_count <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_wb_arbiter
// Brief    : Self-checking bench for usb_wb_arbiter: transaction-level model,
//            per-cycle compare, plus directed scenarios with literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_wb_arbiter;

    localparam int c_TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      mStb, mWe, ack, err, grant;
    logic [1:0][8:0] mAdr;
    logic [1:0][7:0] mDat, datO;
    logic [7:0]      sAdr, sDat, hostDat, slaveDat;
    logic            sWe, hostStb, slaveStb, hostAck, slaveAck, busy;

    int hostLat, slaveLat, hostCnt, slaveCnt;
    int nChecks = 0;
    int nFail   = 0;
    int cyc     = 0;
    int hostStbTot = 0, slaveStbTot = 0;
    int ackTot[2] = '{0, 0};
    int errTot[2] = '{0, 0};
    int gWho[$];
    int gCyc[$];

    always #5 clk = ~clk;

    usb_wb_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .m0_adr_i(mAdr[0]), .m0_dat_i(mDat[0]), .m0_dat_o(datO[0]), .m0_we_i(mWe[0]),
        .m0_stb_i(mStb[0]), .m0_ack_o(ack[0]), .m0_err_o(err[0]),
        .m1_adr_i(mAdr[1]), .m1_dat_i(mDat[1]), .m1_dat_o(datO[1]), .m1_we_i(mWe[1]),
        .m1_stb_i(mStb[1]), .m1_ack_o(ack[1]), .m1_err_o(err[1]),
        .s_adr_o(sAdr), .s_dat_o(sDat), .s_we_o(sWe),
        .host_stb_o(hostStb), .host_dat_i(hostDat), .host_ack_i(hostAck),
        .slave_stb_o(slaveStb), .slave_dat_i(slaveDat), .slave_ack_i(slaveAck),
        .grant_o(grant), .busy_o(busy)
    );

    // Slave responders: ack on the Nth consecutive strobe cycle (0 = never ack).
    assign hostAck  = (hostLat != 0) && hostStb && (hostCnt == hostLat - 1);
    assign slaveAck = (slaveLat != 0) && slaveStb && (slaveCnt == slaveLat - 1);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hostCnt  <= 0;
            slaveCnt <= 0;
        end else begin
            hostCnt  <= (hostStb && !hostAck) ? hostCnt + 1 : 0;
            slaveCnt <= (slaveStb && !slaveAck) ? slaveCnt + 1 : 0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Event monitor: strobe/ack/err tallies and a log of every new grant.
    logic [1:0] prevGrant = 2'b00;
    always @(negedge clk) begin
        if (hostStb)  hostStbTot++;
        if (slaveStb) slaveStbTot++;
        for (int k = 0; k < 2; k++) begin
            if (ack[k]) ackTot[k]++;
            if (err[k]) errTot[k]++;
        end
        if (grant != 2'b00 && prevGrant == 2'b00) begin
            gWho.push_back(grant[1] ? 1 : 0);
            gCyc.push_back(cyc);
        end
        prevGrant = grant;
    end

    // Transaction-level model: owner (-1 = none), age of the current access,
    // a pending release cycle, and the last master served.
    int owner = -1;
    int age   = 0;
    bit inRel = 1'b0;
    int lastM = 1;

    always @(negedge clk) begin : b_cmp
        logic [1:0] eGrant, eAck, eErr;
        logic [7:0] eDat0, eDat1, eAdr, eSdat;
        logic       eWe, eHost, eSlave, eBusy, stb, sel, a;
        eGrant = '0; eAck = '0; eErr = '0; eDat0 = '0; eDat1 = '0;
        eAdr = '0; eSdat = '0; eWe = 1'b0; eHost = 1'b0; eSlave = 1'b0;
        stb = 1'b0; sel = 1'b0; a = 1'b0;
        eBusy = !rst && (inRel || owner >= 0);
        if (!rst && owner >= 0) begin
            stb = mStb[owner];
            sel = mAdr[owner][8];
            eGrant[owner] = 1'b1;
            eAdr   = mAdr[owner][7:0];
            eSdat  = mDat[owner];
            eWe    = mWe[owner];
            eHost  = stb && !sel;
            eSlave = stb && sel;
            a = stb && (sel ? slaveAck : hostAck);
            eAck[owner] = a;
            eErr[owner] = stb && !a && (age == c_TIMEOUT - 1);
            if (owner == 0) eDat0 = sel ? slaveDat : hostDat;
            else            eDat1 = sel ? slaveDat : hostDat;
        end
        check("grant", grant, eGrant);
        check("busy", busy, eBusy);
        check("strobes", {hostStb, slaveStb}, {eHost, eSlave});
        check("ack", ack, eAck);
        check("err", err, eErr);
        check("m0_dat", datO[0], eDat0);
        check("m1_dat", datO[1], eDat1);
        check("s_bus", {sAdr, sDat, sWe}, {eAdr, eSdat, eWe});
        if (rst) begin
            owner = -1; age = 0; inRel = 1'b0; lastM = 1;
        end else if (inRel) begin
            inRel = 1'b0;
        end else if (owner < 0) begin
            if (mStb != 2'b00) begin
                owner = (mStb == 2'b11) ? (lastM == 1 ? 0 : 1) : (mStb[0] ? 0 : 1);
                age   = 0;
            end
        end else if (!stb) begin
            owner = -1;
        end else if (a || eErr[owner]) begin
            lastM = owner;
            owner = -1;
            inRel = 1'b1;
        end else begin
            age++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int h0, s0, a0, a1, e0, g0, n;
    bit seen;

    initial begin
        rst = 1'b1; mStb = '0; mWe = '0; mAdr = '0; mDat = '0;
        hostLat = 0; slaveLat = 0; hostDat = '0; slaveDat = '0;
        @(negedge clk);
        check("rst_grant", grant, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_strobes", {hostStb, slaveStb}, 2'b00);
        step(2); rst = 1'b0; step(1);

        // 1: m0 read of host 0x005, host acks on the 2nd BUSY cycle
        h0 = hostStbTot; s0 = slaveStbTot; a0 = ackTot[0];
        hostLat = 2; hostDat = 8'hA5; mAdr[0] = 9'h005; mStb[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ack[0]) begin seen = 1'b1; check("t1_m0_dat", datO[0], 8'hA5); end
        end
        if (!seen) check("t1_ack_wait", 0, 1);
        step(1); mStb[0] = 1'b0; step(3);
        check("t1_host_stb_cycles", hostStbTot - h0, 2);
        check("t1_slave_stb_cycles", slaveStbTot - s0, 0);
        check("t1_ack_cycles", ackTot[0] - a0, 1);

        // 2: m1 write 0x1C3 = 0x5A to the usbSlave
        a1 = ackTot[1]; h0 = hostStbTot;
        slaveLat = 1; slaveDat = 8'h3C;
        mAdr[1] = 9'h1C3; mDat[1] = 8'h5A; mWe[1] = 1'b1; mStb[1] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ack[1]) begin
                seen = 1'b1;
                check("t2_s_adr", sAdr, 8'hC3);
                check("t2_s_dat", sDat, 8'h5A);
                check("t2_s_we", sWe, 1'b1);
                check("t2_slave_stb", slaveStb, 1'b1);
            end
        end
        if (!seen) check("t2_ack_wait", 0, 1);
        step(1); mStb[1] = 1'b0; mWe[1] = 1'b0; step(3);
        check("t2_ack_cycles", ackTot[1] - a1, 1);
        check("t2_host_stb_cycles", hostStbTot - h0, 0);

        // 3: both masters strobe continuously from reset
        rst = 1'b1; step(2); rst = 1'b0;
        hostLat = 1; mAdr[0] = 9'h020; mAdr[1] = 9'h030;
        g0 = gWho.size(); mStb = 2'b11;
        for (int i = 0; i < 40 && gWho.size() < g0 + 4; i++) @(negedge clk);
        step(1); mStb = 2'b00; step(3);
        if (gWho.size() < g0 + 4) check("t3_grant_wait", 0, 1);
        else begin
            for (int k = 0; k < 4; k++) check("t3_grant_order", gWho[g0 + k], k % 2);
            for (int k = 1; k < 4; k++) check("t3_grant_gap", gCyc[g0 + k] - gCyc[g0 + k - 1], 3);
        end

        // 4: m0 access with no slave ack -> timeout
        a0 = ackTot[0]; e0 = errTot[0];
        hostLat = 0; mAdr[0] = 9'h010; mStb[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (err[0]) begin
                seen = 1'b1;
                check("t4_err_busy_cycle", cyc - gCyc[gCyc.size() - 1] + 1, c_TIMEOUT);
            end
        end
        if (!seen) check("t4_err_wait", 0, 1);
        step(1); mStb[0] = 1'b0;
        @(negedge clk);
        check("t4_release", {busy, grant}, 3'b100);
        step(2);
        check("t4_ack_cycles", ackTot[0] - a0, 0);
        check("t4_err_cycles", errTot[0] - e0, 1);

        // 5: m0 aborts on its 3rd BUSY cycle, pending m1 is served next
        slaveLat = 1; mAdr[0] = 9'h011; mAdr[1] = 9'h105;
        mStb[0] = 1'b1; step(1);
        mStb[1] = 1'b1; step(2);
        mStb[0] = 1'b0;
        @(negedge clk);
        check("t5_abort_no_ack_err", {ack[0], err[0]}, 2'b00);
        n = 0; seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk); n++;
            if (grant == 2'b10) begin seen = 1'b1; check("t5_m1_ack", ack[1], 1'b1); end
        end
        check("t5_m1_grant_delay", seen ? n : 99, 2);
        step(1); mStb[1] = 1'b0; step(2);

        // 6: reset asserted mid-BUSY with a host ack pending
        hostLat = 3; hostDat = 8'h77; mAdr[0] = 9'h005; mStb[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (grant[0]) seen = 1'b1;
        end
        check("t6_pre_host_stb", seen ? hostStb : 1'b0, 1'b1);
        #2 rst = 1'b1; mStb[1] = 1'b1;
        #1;
        check("t6_async_host_stb", hostStb, 1'b0);
        check("t6_async_ack", ack[0], 1'b0);
        check("t6_async_grant", grant, 2'b00);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t6_idle_grant", grant, 2'b00);
        @(negedge clk);
        check("t6_first_tie", grant, 2'b01);
        step(1); mStb = 2'b00; step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
